// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso_tx serial transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int PISO_WIDTH_DEF = 4;

endpackage

// File: rtl/piso_tx_if.sv
// Load handshake plus serial line of piso_tx; the transmitter takes the slave side.
interface piso_tx_if
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF
);

    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             dout;
    logic             dout_valid;
    logic             word_done;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  dout,
        input  dout_valid,
        input  word_done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output dout,
        output dout_valid,
        output word_done
    );

endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: one WIDTH-bit word per frame, LSB first.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    piso_tx_if.slave bus
);

`ifdef PISO_TX_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    piso_state_t      state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             dout_valid_q, dout_valid_n;
    logic             word_done_q, word_done_n;
    logic             last_bit;
    logic             ready;
    logic             accept;
`ifdef PISO_TX_PARITY_EN
    logic             par, par_n;
`endif

    // Ready depends on state and counter only, so a frame boundary can take the next word.
    assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);
    assign ready    = (state == IDLE) || last_bit;
    assign accept   = bus.load_valid && ready;

    // shreg[0] is the line bit; shreg is cleared whenever no frame is running.
    assign bus.load_ready = ready;
    assign bus.dout       = shreg[0];
    assign bus.dout_valid = dout_valid_q;
    assign bus.word_done  = word_done_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_n      = state;
        shreg_n      = shreg;
        cnt_n        = cnt;
        dout_valid_n = 1'b0;
        word_done_n  = 1'b0;
`ifdef PISO_TX_PARITY_EN
        par_n        = par;
`endif
        if (accept) begin
            state_n      = SHIFT;
            shreg_n      = bus.load_data;
            cnt_n        = '0;
            dout_valid_n = 1'b1;
`ifdef PISO_TX_PARITY_EN
            par_n        = ^bus.load_data;
`endif
        end else if ((state == SHIFT) && !last_bit) begin
            // Parity is shifted in at the top so it reaches bit 0 right after the last data bit.
`ifdef PISO_TX_PARITY_EN
            shreg_n = {par, shreg[WIDTH-1:1]};
`else
            shreg_n = {1'b0, shreg[WIDTH-1:1]};
`endif
            cnt_n        = cnt + CNT_W'(1);
            dout_valid_n = 1'b1;
            word_done_n  = (cnt_n == LAST_CNT);
        end else begin
            state_n = IDLE;
            shreg_n = '0;
            cnt_n   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shreg        <= '0;
            cnt          <= '0;
            dout_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
        end else begin
            state        <= state_n;
            shreg        <= shreg_n;
            cnt          <= cnt_n;
            dout_valid_q <= dout_valid_n;
            word_done_q  <= word_done_n;
        end
    end

`ifdef PISO_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else begin
            par <= par_n;
        end
    end
`endif

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: vector table, corner sequences and a
// scoreboard/receiver monitor that follows every frame on the line.
module tb_piso_tx;

    localparam int W = piso_pkg::PISO_WIDTH_DEF;
`ifdef PISO_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    typedef struct {
        logic [W-1:0]  data;
        logic [FL-1:0] stream;   // first transmitted bit at the MSB
    } vec_t;

    typedef struct {
        logic b;
        logic last;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;

    piso_tx_if #(.WIDTH(W)) bus ();

    piso_tx #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    sb_t          exp_q[$];
    logic [W-1:0] word_q[$];
    logic [W-1:0] rx;
    int           rx_idx;
    sb_t          e;
    vec_t         tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard and bench receiver, sampled mid-cycle away from the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("sb_valid", bus.dout_valid, exp_q.size() != 0);
            if (bus.dout_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_dout", bus.dout, e.b);
                check("sb_done", bus.word_done, e.last);
                if (rx_idx < W) rx = {bus.dout, rx[W-1:1]};
                else check("rx_parity", bus.dout, ^rx);
                rx_idx++;
                if (e.last) begin
                    if (word_q.size() == 0) check("rx_no_word", 1, 0);
                    else check("rx_word", rx, word_q.pop_front());
                    rx_idx = 0;
                end
            end else if (!bus.dout_valid) begin
                check("sb_idle_out", {bus.dout, bus.word_done}, 0);
            end
            check("sb_ready", bus.load_ready, exp_q.size() == 0);
            if (bus.load_valid && bus.load_ready) begin
                for (int i = 0; i < FL; i++) begin
                    exp_q.push_back('{b: (i < W) ? bus.load_data[i] : ^bus.load_data,
                                      last: (i == FL - 1)});
                end
                word_q.push_back(bus.load_data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer a word and return at posedge+1 of the cycle that carries its bit 0.
    task automatic send(input logic [W-1:0] d, input bit keep);
        bit got = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            got = bus.load_ready;
            @(posedge clk);
            #1;
        end
        if (!got) check("send_timeout", 0, 1);
        if (!keep) bus.load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int n = 0; n < 64 && !idle; n++) begin
            @(negedge clk);
            idle = !bus.dout_valid;
        end
        if (!idle) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2*FL-1:0] got_s, got_r, exp_s, exp_r;
        int              waited;

`ifdef PISO_TX_PARITY_EN
        tbl[0] = '{4'b0111, 5'b11101};
        tbl[1] = '{4'b0101, 5'b10100};
        tbl[2] = '{4'b1011, 5'b11011};
        tbl[3] = '{4'b0000, 5'b00000};
        tbl[4] = '{4'b1000, 5'b00011};
        exp_s  = 10'b01010_10100;
        exp_r  = 10'b00001_00001;
`else
        tbl[0] = '{4'b1011, 4'b1101};
        tbl[1] = '{4'b0000, 4'b0000};
        tbl[2] = '{4'b1111, 4'b1111};
        tbl[3] = '{4'b0001, 4'b1000};
        tbl[4] = '{4'b0110, 4'b0110};
        exp_s  = 8'b0101_1010;
        exp_r  = 8'b0001_0001;
`endif
        rx     = '0;
        rx_idx = 0;

        // Reset state
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        check("rst_dout", bus.dout, 0);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_word_done", bus.word_done, 0);
        check("rst_load_ready", bus.load_ready, 1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-word vectors
        foreach (tbl[v]) begin
            wait_idle();
            send(tbl[v].data, 1'b0);
            for (int i = 0; i < FL; i++) begin
                @(negedge clk);
                check("tbl_dout", bus.dout, tbl[v].stream[FL-1-i]);
                check("tbl_valid", bus.dout_valid, 1);
                check("tbl_done", bus.word_done, i == FL - 1);
                if (i < FL - 1) begin
                    @(posedge clk);
                    #1;
                end
            end
            @(posedge clk);
            #1;
            @(negedge clk);
            check("tbl_idle_dout", bus.dout, 0);
            check("tbl_idle_valid", bus.dout_valid, 0);
        end

        // Back-to-back: load_valid held across 4'hA then 4'h5
        wait_idle();
        send(4'hA, 1'b1);
        bus.load_data = 4'h5;
        for (int c = 0; c < 2 * FL; c++) begin
            @(negedge clk);
            got_s[2*FL-1-c] = bus.dout;
            got_r[2*FL-1-c] = bus.load_ready;
            @(posedge clk);
            #1;
            if (c == FL - 1) bus.load_valid = 1'b0;
        end
        check("b2b_stream", 32'(got_s), 32'(exp_s));
        check("b2b_ready", 32'(got_r), 32'(exp_r));

        // Stall: word offered during bit 1 waits for the last-bit cycle
        wait_idle();
        send(4'b1110, 1'b0);
        @(posedge clk);
        #1;
        bus.load_valid = 1'b1;
        bus.load_data  = 4'b0001;
        waited = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.load_ready) break;
            waited++;
            @(posedge clk);
            #1;
        end
        check("stall_wait", waited, FL - 2);
        check("stall_done_at_ready", bus.word_done, 1);
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        @(negedge clk);
        check("stall_next_bit0", bus.dout, 1);
        check("stall_next_valid", bus.dout_valid, 1);
        check("stall_next_done", bus.word_done, 0);

        // Reset during bit 2 of 4'hF
        wait_idle();
        send(4'hF, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_dout", bus.dout, 0);
        check("mid_rst_valid", bus.dout_valid, 0);
        check("mid_rst_done", bus.word_done, 0);
        check("mid_rst_ready", bus.load_ready, 1);
        exp_q.delete();
        word_q.delete();
        rx_idx = 0;
        rx     = '0;
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", bus.dout_valid, 0);
        check("post_rst_done", bus.word_done, 0);
        @(posedge clk);
        #1;
        send(4'h9, 1'b0);
        wait_idle();

        // Loopback of random words, mixing held valid and idle gaps
        for (int n = 0; n < 1000; n++) begin
            bit keep;
            keep = 1'($urandom_range(0, 1));
            send(W'($urandom_range(0, (1 << W) - 1)), keep);
            if (!keep) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        bus.load_valid = 1'b0;
        wait_idle();
        wait_idle();
        check("drained_bits", exp_q.size(), 0);
        check("drained_words", word_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
